// File: rtl/issue_queue_entry_allocator.sv
// Free-list manager for issue queue entry indices: hands out up to ALLOC_WIDTH
// free indices per cycle and takes back up to RELEASE_WIDTH freed ones.
module issue_queue_entry_allocator #(
    parameter int unsigned ENTRY_NUM     = 16,
    parameter int unsigned INDEX_WIDTH   = 4,
    parameter int unsigned ALLOC_WIDTH   = 2,
    parameter int unsigned RELEASE_WIDTH = 2,
    parameter int unsigned COUNT_WIDTH   = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ALLOC_WIDTH-1:0]                 allocate,
    output logic [ALLOC_WIDTH*INDEX_WIDTH-1:0]     allocatedPtr,
    output logic                                   allocatable,
    input  logic [RELEASE_WIDTH-1:0]               releaseValid,
    input  logic [RELEASE_WIDTH*INDEX_WIDTH-1:0]   releasePtr,
    input  logic                                   flush,
    output logic [COUNT_WIDTH-1:0]                 freeCount,
    output logic                                   allocError,
    output logic                                   releaseError
);

    localparam int unsigned SUM_WIDTH = COUNT_WIDTH + 1;

    logic [INDEX_WIDTH-1:0] freeList [ENTRY_NUM];
    logic [INDEX_WIDTH-1:0] head;
    logic [INDEX_WIDTH-1:0] tail;
    logic [COUNT_WIDTH-1:0] count;

    logic [COUNT_WIDTH-1:0] nAlloc;
    logic [COUNT_WIDTH-1:0] nRel;
    logic [INDEX_WIDTH-1:0] relSlot [RELEASE_WIDTH];
    logic [SUM_WIDTH-1:0]   countSum;
    logic                   relDrop;
    logic                   allocReject;

    // Zero-latency peek of the next ALLOC_WIDTH free indices
    always_comb begin
        allocatedPtr = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            allocatedPtr[i*INDEX_WIDTH +: INDEX_WIDTH] = freeList[head + INDEX_WIDTH'(i)];
        end
    end

    assign allocatable = (count >= COUNT_WIDTH'(ALLOC_WIDTH));
    assign freeCount   = count;

    // Lane accounting; set release lanes are compacted onto consecutive tail slots
    always_comb begin
        nAlloc      = '0;
        nRel        = '0;
        allocReject = (|allocate) & ~allocatable;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            if (allocatable && allocate[i]) begin
                nAlloc = nAlloc + COUNT_WIDTH'(1);
            end
        end
        for (int unsigned j = 0; j < RELEASE_WIDTH; j++) begin
            relSlot[j] = tail + INDEX_WIDTH'(nRel);
            if (releaseValid[j]) begin
                nRel = nRel + COUNT_WIDTH'(1);
            end
        end
        countSum = SUM_WIDTH'(count) - SUM_WIDTH'(nAlloc) + SUM_WIDTH'(nRel);
        relDrop  = (countSum > SUM_WIDTH'(ENTRY_NUM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
                freeList[k] <= INDEX_WIDTH'(k);
            end
            head         <= '0;
            tail         <= '0;
            count        <= COUNT_WIDTH'(ENTRY_NUM);
            allocError   <= 1'b0;
            releaseError <= 1'b0;
        end else if (flush) begin
            // Flush restores the free list but keeps the sticky error flags
            for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
                freeList[k] <= INDEX_WIDTH'(k);
            end
            head  <= '0;
            tail  <= '0;
            count <= COUNT_WIDTH'(ENTRY_NUM);
        end else begin
            head <= head + INDEX_WIDTH'(nAlloc);
            if (allocReject) begin
                allocError <= 1'b1;
            end
            if (relDrop) begin
                releaseError <= 1'b1;
                count        <= count - nAlloc;
            end else begin
                for (int unsigned j = 0; j < RELEASE_WIDTH; j++) begin
                    if (releaseValid[j]) begin
                        freeList[relSlot[j]] <= releasePtr[j*INDEX_WIDTH +: INDEX_WIDTH];
                    end
                end
                tail  <= tail + INDEX_WIDTH'(nRel);
                count <= COUNT_WIDTH'(countSum);
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_entry_allocator.sv
// Bench for issue_queue_entry_allocator: free-list model plus a grant scoreboard.
module tb_issue_queue_entry_allocator;

    localparam int unsigned EN = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned RW = 2;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] allocate = '0;
    logic [AW*IW-1:0] allocatedPtr;
    logic          allocatable;
    logic [RW-1:0] releaseValid = '0;
    logic [RW*IW-1:0] releasePtr = '0;
    logic          flush = 1'b0;
    logic [CW-1:0] freeCount;
    logic          allocError;
    logic          releaseError;

    int freeQ[$];
    int expQ[$];
    bit held[EN];
    bit expAllocErr;
    bit expRelErr;
    int lastGrant;
    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    issue_queue_entry_allocator #(
        .ENTRY_NUM(EN), .INDEX_WIDTH(IW), .ALLOC_WIDTH(AW),
        .RELEASE_WIDTH(RW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .allocate(allocate), .allocatedPtr(allocatedPtr),
        .allocatable(allocatable), .releaseValid(releaseValid), .releasePtr(releasePtr),
        .flush(flush), .freeCount(freeCount), .allocError(allocError),
        .releaseError(releaseError)
    );

    // Allocation requests must be prefix-contiguous
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(allocate[1] && !allocate[0])) else begin
                nMis++;
                $display("FAIL non-prefix allocate: got %b", allocate);
            end
        end
    end

    task automatic model_reset(input bit clrFlags);
        freeQ.delete();
        for (int k = 0; k < int'(EN); k++) begin
            freeQ.push_back(k);
            held[k] = 1'b0;
        end
        if (clrFlags) begin
            expAllocErr = 1'b0;
            expRelErr   = 1'b0;
        end
    endtask

    // One clock: drive inputs, score granted lanes, then advance the model
    task automatic cycle(input logic [1:0] a, input logic [1:0] rv, input int p0,
                         input int p1, input logic fl, input logic r);
        int n;
        int newc;
        int got;
        int exp_;
        bit grantable;
        @(negedge clk);
        rst          = r;
        flush        = fl;
        allocate     = a;
        releaseValid = rv;
        releasePtr   = {4'(p1), 4'(p0)};
        grantable    = !r && !fl && (freeQ.size() >= int'(AW));
        for (int i = 0; i < int'(AW); i++) begin
            if (grantable && a[i]) expQ.push_back(freeQ[i]);
        end
        for (int i = 0; i < int'(AW); i++) begin
            if (grantable && a[i]) begin
                got  = int'(allocatedPtr[i*IW +: IW]);
                exp_ = expQ.pop_front();
                nVec++;
                if (got !== exp_) begin
                    nMis++;
                    $display("FAIL grant lane%0d: got %0d, expected %0d", i, got, exp_);
                end
                nVec++;
                if (held[got]) begin
                    nMis++;
                    $display("FAIL duplicate grant lane%0d: index %0d already outstanding", i, got);
                end
            end
        end
        @(posedge clk);
        if (r) begin
            model_reset(1'b1);
        end else if (fl) begin
            model_reset(1'b0);
        end else begin
            n = 0;
            if (a != 2'b00) begin
                if (freeQ.size() >= int'(AW)) n = $countones(a);
                else expAllocErr = 1'b1;
            end
            newc = freeQ.size() - n + $countones(rv);
            for (int i = 0; i < n; i++) begin
                lastGrant = freeQ.pop_front();
                held[lastGrant] = 1'b1;
            end
            if (newc > int'(EN)) begin
                expRelErr = 1'b1;
            end else begin
                if (rv[0]) begin freeQ.push_back(p0); held[p0] = 1'b0; end
                if (rv[1]) begin freeQ.push_back(p1); held[p1] = 1'b0; end
            end
        end
        #1;
    endtask

    task automatic release_all();
        int idx[$];
        int x;
        int y;
        for (int k = 0; k < int'(EN); k++) if (held[k]) idx.push_back(k);
        while (idx.size() >= 2) begin
            x = idx.pop_front();
            y = idx.pop_front();
            cycle(2'b00, 2'b11, x, y, 1'b0, 1'b0);
        end
        if (idx.size() == 1) begin
            x = idx.pop_front();
            cycle(2'b00, 2'b01, x, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
        nVec++;
        if (freeCount !== 5'd16) begin nMis++; $display("FAIL reset freeCount: got %0d, expected 16", freeCount); end
        nVec++;
        if (allocatable !== 1'b1) begin nMis++; $display("FAIL reset allocatable: got %b, expected 1", allocatable); end
        nVec++;
        if (allocatedPtr !== 8'h10) begin nMis++; $display("FAIL reset allocatedPtr: got %h, expected 10", allocatedPtr); end
        nVec++;
        if (allocError !== 1'b0 || releaseError !== 1'b0) begin
            nMis++; $display("FAIL reset flags: got %b%b, expected 00", allocError, releaseError);
        end
    endtask

    task automatic test_alloc_drain();
        for (int k = 0; k < 8; k++) begin
            nVec++;
            if (freeCount !== CW'(16 - 2*k)) begin
                nMis++; $display("FAIL drain freeCount step%0d: got %0d, expected %0d", k, freeCount, 16 - 2*k);
            end
            cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        end
        nVec++;
        if (freeCount !== 5'd0) begin nMis++; $display("FAIL drain final freeCount: got %0d, expected 0", freeCount); end
        nVec++;
        if (allocatable !== 1'b0) begin nMis++; $display("FAIL drain allocatable: got %b, expected 0", allocatable); end
    endtask

    task automatic test_alloc_error();
        cycle(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (allocError !== 1'b1) begin nMis++; $display("FAIL allocError set: got %b, expected 1", allocError); end
        nVec++;
        if (freeCount !== 5'd0) begin nMis++; $display("FAIL rejected alloc freeCount: got %0d, expected 0", freeCount); end
        cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (allocError !== 1'b1) begin nMis++; $display("FAIL allocError sticky: got %b, expected 1", allocError); end
        cycle(2'b00, 2'b11, 5, 9, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd2) begin nMis++; $display("FAIL release freeCount: got %0d, expected 2", freeCount); end
        nVec++;
        if (allocatedPtr !== 8'h95) begin nMis++; $display("FAIL release allocatedPtr: got %h, expected 95", allocatedPtr); end
    endtask

    task automatic test_same_cycle();
        cycle(2'b00, 2'b11, 0, 1, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd4) begin nMis++; $display("FAIL setup freeCount: got %0d, expected 4", freeCount); end
        cycle(2'b11, 2'b10, 0, 7, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd3) begin nMis++; $display("FAIL same-cycle freeCount: got %0d, expected 3", freeCount); end
        nVec++;
        if (allocatedPtr !== 8'h10) begin nMis++; $display("FAIL same-cycle allocatedPtr: got %h, expected 10", allocatedPtr); end
        cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (allocatedPtr[3:0] !== 4'd7) begin nMis++; $display("FAIL appended index: got %0d, expected 7", allocatedPtr[3:0]); end
        nVec++;
        if (freeCount !== 5'd1 || allocatable !== 1'b0) begin
            nMis++; $display("FAIL tail state: got count %0d alloc %b, expected 1 0", freeCount, allocatable);
        end
        release_all();
        nVec++;
        if (freeCount !== 5'd16) begin nMis++; $display("FAIL refill freeCount: got %0d, expected 16", freeCount); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 20; k++) begin
            cycle(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
            cycle(2'b00, 2'b01, lastGrant, 0, 1'b0, 1'b0);
        end
        nVec++;
        if (freeCount !== 5'd16) begin nMis++; $display("FAIL wrap freeCount: got %0d, expected 16", freeCount); end
        for (int k = 0; k < 8; k++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd0) begin nMis++; $display("FAIL wrap drain freeCount: got %0d, expected 0", freeCount); end
        release_all();
        nVec++;
        if (freeCount !== CW'(freeQ.size())) begin
            nMis++; $display("FAIL wrap refill freeCount: got %0d, expected %0d", freeCount, freeQ.size());
        end
    endtask

    task automatic test_release_overflow();
        cycle(2'b00, 2'b01, 3, 0, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd16) begin nMis++; $display("FAIL overflow freeCount: got %0d, expected 16", freeCount); end
        nVec++;
        if (releaseError !== 1'b1) begin nMis++; $display("FAIL releaseError set: got %b, expected 1", releaseError); end
        cycle(2'b01, 2'b11, 3, 4, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd15) begin nMis++; $display("FAIL overflow with alloc freeCount: got %0d, expected 15", freeCount); end
        nVec++;
        if (allocatedPtr[3:0] !== 4'(freeQ[0])) begin
            nMis++; $display("FAIL overflow head: got %0d, expected %0d", allocatedPtr[3:0], freeQ[0]);
        end
        release_all();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd5) begin nMis++; $display("FAIL pre-flush freeCount: got %0d, expected 5", freeCount); end
        cycle(2'b11, 2'b11, lastGrant, freeQ[0], 1'b1, 1'b0);
        nVec++;
        if (freeCount !== 5'd16) begin nMis++; $display("FAIL flush freeCount: got %0d, expected 16", freeCount); end
        nVec++;
        if (allocatedPtr !== 8'h10) begin nMis++; $display("FAIL flush allocatedPtr: got %h, expected 10", allocatedPtr); end
        cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (allocError !== expAllocErr || releaseError !== expRelErr || allocError !== 1'b1 || releaseError !== 1'b1) begin
            nMis++; $display("FAIL flush flags: got %b%b, expected 11", allocError, releaseError);
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 3; k++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd10) begin nMis++; $display("FAIL pre-reset freeCount: got %0d, expected 10", freeCount); end
        cycle(2'b11, 2'b01, 0, 0, 1'b0, 1'b1);
        nVec++;
        if (freeCount !== 5'd16 || allocatedPtr !== 8'h10) begin
            nMis++; $display("FAIL midrun reset state: got count %0d ptr %h, expected 16 10", freeCount, allocatedPtr);
        end
        nVec++;
        if (allocError !== 1'b0 || releaseError !== 1'b0) begin
            nMis++; $display("FAIL midrun reset flags: got %b%b, expected 00", allocError, releaseError);
        end
        cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        nVec++;
        if (freeCount !== 5'd14 || allocatedPtr !== 8'h32) begin
            nMis++; $display("FAIL post-reset alloc: got count %0d ptr %h, expected 14 32", freeCount, allocatedPtr);
        end
    endtask

    initial begin
        model_reset(1'b1);
        test_reset();
        test_alloc_drain();
        test_alloc_error();
        test_same_cycle();
        test_wrap();
        test_release_overflow();
        test_flush();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/issue_queue_entry_allocator.md
Name: issue_queue_entry_allocator

Overview:
Free-list manager for issue queue entry indices. It is the responder to the rename-stage allocation request (allocate, allocatedPtr, allocatable). Each cycle it hands out up to ALLOC_WIDTH free indices and takes back up to RELEASE_WIDTH indices freed by issue or replay completion. A full flush restores every entry to free.

Parameters:
ENTRY_NUM, 16, issue queue entry count; power of two, at least 4.
INDEX_WIDTH, 4, log2(ENTRY_NUM).
ALLOC_WIDTH, 2, allocation lanes; equals RENAME_WIDTH.
RELEASE_WIDTH, 2, release lanes; equals ISSUE_WIDTH.
COUNT_WIDTH, 5, log2(ENTRY_NUM)+1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
allocate  in  ALLOC_WIDTH  per-lane allocation request; must be prefix-contiguous (lane i set implies lane i-1 set).
allocatedPtr  out  ALLOC_WIDTH*INDEX_WIDTH  index offered on each lane; lane i occupies bits [i*INDEX_WIDTH +: INDEX_WIDTH].
allocatable  out  1  at least ALLOC_WIDTH free entries exist.
release  in  RELEASE_WIDTH  per-lane release valid; any pattern is legal.
releasePtr  in  RELEASE_WIDTH*INDEX_WIDTH  index being freed on each lane.
flush  in  1  return all entries to free.
freeCount  out  COUNT_WIDTH  current number of free entries.
allocError  out  1  registered flag: allocate seen while allocatable=0.
releaseError  out  1  registered flag: release would push freeCount above ENTRY_NUM.

Behaviour:
- Storage: circular FIFO freeList[ENTRY_NUM] of INDEX_WIDTH bits, with head and tail pointers (INDEX_WIDTH bits, wrap modulo ENTRY_NUM) and a count register.
- Reset (rst=1 at a clock edge): freeList[k]=k for all k, head=0, tail=0, count=ENTRY_NUM, allocError=0, releaseError=0. Completes in one cycle, including mid-operation; all other inputs are ignored that cycle.
- Outputs:
  - allocatedPtr lane i = freeList[(head+i) mod ENTRY_NUM]. Combinational from registered state, zero-latency peek, valid regardless of allocate.
  - allocatable = (count >= ALLOC_WIDTH). Combinational.
  - freeCount = count.
  - After reset: allocatedPtr = {1,0} for ALLOC_WIDTH=2, allocatable=1, freeCount=16.
- Allocation: nAlloc = popcount(allocate), counted only when allocatable=1. Next head = head+nAlloc.
  - allocate while allocatable=0: no state change, allocError set next cycle. allocError is sticky until rst.
  - Non-prefix allocate pattern: illegal; the bench asserts on it.
- Release: set lanes are compacted in lane order. The j-th set lane writes freeList[(tail+j) mod ENTRY_NUM]. nRel = popcount(release). Next tail = tail+nRel.
- Same cycle: next count = count - nAlloc + nRel.
  - A released index is not visible on allocatedPtr until the next cycle. There is no bypass.
  - Push and pop slots cannot collide, because count >= ALLOC_WIDTH is required to pop.
- Overflow: if count - nAlloc + nRel > ENTRY_NUM, the release is dropped (tail and count unchanged by release), releaseError is set next cycle and is sticky. Allocation still proceeds.
- Flush: priority rst > flush > allocate/release. Flush behaves as reset of freeList, head, tail and count in one cycle, but does not clear the error flags. Allocate and release in a flush cycle are discarded.
- Wrap-around: pointer arithmetic is INDEX_WIDTH-bit modulo. There is no full/empty ambiguity because count is explicit.
- No duplicate detection; duplicate release is a caller bug. The bench checks uniqueness.
- Invariant: the multiset of indices in freeList[head .. head+count-1] plus outstanding allocations equals {0..ENTRY_NUM-1}.

Test Plan:
1. Reset, then allocate=2'b11 for 8 cycles -> allocatedPtr pairs {1,0},{3,2},...,{15,14}; freeCount 16,14,...,2,0; allocatable drops to 0 when freeCount=0.
2. With freeCount=0: allocate=2'b01 -> no head move, allocError=1 next cycle and stays 1; then release=2'b11 with ptrs {5,9} -> freeCount=2, allocatedPtr={9,5} next cycle.
3. From freeCount=4, same cycle allocate=2'b11 and release=2'b10 with lane1 ptr=7 -> freeCount=3; index 7 is appended at the tail, not offered that cycle.
4. Wrap: churn allocate/release of a single entry 20 times from full -> head and tail wrap past 15, freeCount stays 16 at quiescence, no index is lost (scoreboard).
5. Mid-run flush with freeCount=5 and outstanding allocations -> next cycle freeCount=16, allocatedPtr={1,0}, error flags preserved; rst mid-run additionally clears the flags.
6. At freeCount=16, release=2'b01 ptr=3 -> release dropped, releaseError=1, freeCount stays 16.
